// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rxd, qualifies the start bit at its centre,
// samples each data/stop bit at its centre and strobes rx_done or frame_err.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rxd,
    output logic [7:0] o_data_out,
    output logic       o_rx_done,
    output logic       o_frame_err,
    output logic       o_rx_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_done;
    logic             r_err;
    logic             r_busy;
    logic             w_rxs;

    assign w_rxs = r_sync2;

    // Synchroniser flops reset high so releasing reset never looks like a start bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rxs) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_cnt == HALF_CNT) begin
                        if (!w_rxs) begin
                            r_cnt   <= '0;
                            r_idx   <= '0;
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_cnt == LAST_CNT) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxs, r_shift[7:1]};
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Leaving at the stop-bit centre lets a gapless next start bit be caught.
                S_STOP: begin
                    if (r_cnt == LAST_CNT) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_data  <= r_shift;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_BREAK: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_data_out  = r_data;
    assign o_rx_done   = r_done;
    assign o_frame_err = r_err;
    assign o_rx_busy   = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a bit-accurate serial model drives rxd at
// CLKS_PER_BIT=16 and each scenario task checks the receiver's responses.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic [7:0] dataOut;
    logic       rxDone;
    logic       frameErr;
    logic       rxBusy;

    int checks   = 0;
    int failures = 0;

    int       cycle       = 0;
    int       doneCount   = 0;
    int       errCount    = 0;
    int       bothHigh    = 0;
    int       busyRun     = 0;
    int       maxBusyRun  = 0;
    logic [7:0] doneData[$];
    int       doneCycle[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_rxd      (rxd),
        .o_data_out (dataOut),
        .o_rx_done  (rxDone),
        .o_frame_err(frameErr),
        .o_rx_busy  (rxBusy)
    );

    // 20 ns clock period
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Monitor samples on the falling edge, away from the DUT's active edge
    always @(negedge clk) begin
        cycle = cycle + 1;
        if (rxDone === 1'b1) begin
            doneCount = doneCount + 1;
            doneData.push_back(dataOut);
            doneCycle.push_back(cycle);
        end
        if (frameErr === 1'b1) errCount = errCount + 1;
        if (rxDone === 1'b1 && frameErr === 1'b1) bothHigh = bothHigh + 1;
        if (rxBusy === 1'b1) begin
            busyRun = busyRun + 1;
            if (busyRun > maxBusyRun) maxBusyRun = busyRun;
        end else begin
            busyRun = 0;
        end
    end

    task automatic clear_monitor();
        doneCount  = 0;
        errCount   = 0;
        bothHigh   = 0;
        maxBusyRun = 0;
        doneData.delete();
        doneCycle.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stopBit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stopBit);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        wait_cycles(n);
    endtask

    task automatic test_reset();
        rxd   = 1'b1;
        reset = 1'b1;
        wait_cycles(3);
        checks++; if (dataOut !== 8'h00) begin failures++; $display("[TB] FAIL reset_data: got %h expected 00", dataOut); end
        checks++; if (rxDone !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", rxDone); end
        checks++; if (frameErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", frameErr); end
        checks++; if (rxBusy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", rxBusy); end
        reset = 1'b0;
        clear_monitor();
        wait_cycles(10);
        checks++; if (maxBusyRun !== 0) begin failures++; $display("[TB] FAIL reset_release_busy: got %0d busy cycles expected 0", maxBusyRun); end
    endtask

    task automatic test_single();
        int startCycle;
        int latency;
        clear_monitor();
        startCycle = cycle;
        send_frame(8'hAA, 1'b1);
        idle(20);
        checks++; if (doneCount !== 1) begin failures++; $display("[TB] FAIL single_done_count: got %0d expected 1", doneCount); end
        checks++; if (dataOut !== 8'hAA) begin failures++; $display("[TB] FAIL single_data: got %h expected aa", dataOut); end
        checks++; if (errCount !== 0) begin failures++; $display("[TB] FAIL single_err_count: got %0d expected 0", errCount); end
        checks++; if (rxBusy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_after: got %b expected 0", rxBusy); end
        // 2 + (HALF+1) + 9*16 + 1 = 155 cycles, with one cycle of sampling slack
        latency = (doneCycle.size() > 0) ? doneCycle[0] - startCycle : -1;
        checks++; if (latency < 154 || latency > 156) begin failures++; $display("[TB] FAIL single_latency: got %0d expected 155 +/-1", latency); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[3];
        int gap;
        exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h5A;
        clear_monitor();
        for (int f = 0; f < 3; f++) send_frame(exp[f], 1'b1);
        idle(20);
        checks++; if (doneCount !== 3) begin failures++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", doneCount); end
        for (int f = 0; f < 3; f++) begin
            checks++;
            if (doneData.size() <= f || doneData[f] !== exp[f]) begin
                failures++;
                $display("[TB] FAIL b2b_data%0d: got %h expected %h", f, (doneData.size() > f) ? doneData[f] : 8'hxx, exp[f]);
            end
        end
        for (int f = 1; f < 3; f++) begin
            gap = (doneCycle.size() > f) ? doneCycle[f] - doneCycle[f-1] : -1;
            checks++; if (gap < 159 || gap > 161) begin failures++; $display("[TB] FAIL b2b_spacing%0d: got %0d expected 160", f, gap); end
        end
        checks++; if (errCount !== 0) begin failures++; $display("[TB] FAIL b2b_err_count: got %0d expected 0", errCount); end
    endtask

    task automatic test_glitch();
        clear_monitor();
        rxd = 1'b0;
        wait_cycles(4);
        idle(30);
        checks++; if (doneCount !== 0) begin failures++; $display("[TB] FAIL glitch_done: got %0d expected 0", doneCount); end
        checks++; if (errCount !== 0) begin failures++; $display("[TB] FAIL glitch_err: got %0d expected 0", errCount); end
        checks++; if (rxBusy !== 1'b0) begin failures++; $display("[TB] FAIL glitch_busy_after: got %b expected 0", rxBusy); end
        checks++; if (maxBusyRun < 1 || maxBusyRun > 10) begin failures++; $display("[TB] FAIL glitch_busy_len: got %0d expected 1..10", maxBusyRun); end
    endtask

    task automatic test_frame_error();
        clear_monitor();
        send_frame(8'h3C, 1'b0);
        rxd = 1'b0;
        wait_cycles(100);
        idle(30);
        checks++; if (errCount !== 1) begin failures++; $display("[TB] FAIL ferr_count: got %0d expected 1", errCount); end
        checks++; if (doneCount !== 0) begin failures++; $display("[TB] FAIL ferr_done: got %0d expected 0", doneCount); end
        checks++; if (dataOut !== 8'h5A) begin failures++; $display("[TB] FAIL ferr_data_kept: got %h expected 5a", dataOut); end
        checks++; if (rxBusy !== 1'b0) begin failures++; $display("[TB] FAIL ferr_busy_after: got %b expected 0", rxBusy); end
        clear_monitor();
        send_frame(8'hC3, 1'b1);
        idle(20);
        checks++; if (doneCount !== 1) begin failures++; $display("[TB] FAIL ferr_next_count: got %0d expected 1", doneCount); end
        checks++; if (dataOut !== 8'hC3) begin failures++; $display("[TB] FAIL ferr_next_data: got %h expected c3", dataOut); end
        checks++; if (errCount !== 0) begin failures++; $display("[TB] FAIL ferr_next_err: got %0d expected 0", errCount); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] frame;
        frame = 8'h81;
        clear_monitor();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(frame[i]);
        rxd = frame[4];
        wait_cycles(8);
        // The looped-back transmitter shares the reset, so the line returns to idle too
        reset = 1'b1;
        rxd   = 1'b1;
        wait_cycles(2);
        checks++; if (dataOut !== 8'h00) begin failures++; $display("[TB] FAIL abort_data: got %h expected 00", dataOut); end
        checks++; if (rxBusy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b expected 0", rxBusy); end
        checks++; if (rxDone !== 1'b0 || frameErr !== 1'b0) begin failures++; $display("[TB] FAIL abort_pulses: got done=%b err=%b expected 0 0", rxDone, frameErr); end
        reset = 1'b0;
        idle(200);
        checks++; if (doneCount !== 0 || errCount !== 0) begin failures++; $display("[TB] FAIL abort_no_pulse: got done=%0d err=%0d expected 0 0", doneCount, errCount); end
        clear_monitor();
        send_frame(8'h81, 1'b1);
        idle(20);
        checks++; if (doneCount !== 1) begin failures++; $display("[TB] FAIL abort_next_count: got %0d expected 1", doneCount); end
        checks++; if (dataOut !== 8'h81) begin failures++; $display("[TB] FAIL abort_next_data: got %h expected 81", dataOut); end
    endtask

    task automatic test_exclusive();
        checks++; if (bothHigh !== 0) begin failures++; $display("[TB] FAIL done_err_overlap: got %0d cycles expected 0", bothHigh); end
    endtask

    initial begin
        reset = 1'b1;
        rxd   = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_exclusive();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
